// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: Tuse/Tnew data-stall detection, forwarding selects and
// the mult/div busy counter. Optional stall statistics counter under HAZ_STALL_STATS_EN.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tuse_rs0,
  input  logic       Tuse_rs1,
  input  logic       Tuse_rt0,
  input  logic       Tuse_rt1,
  input  logic       Tuse_rt2,
  input  logic [4:0] A1_D,
  input  logic [4:0] A2_D,
  input  logic [4:0] A1_E,
  input  logic [4:0] A2_E,
  input  logic [4:0] A2_M,
  input  logic [4:0] A3_E,
  input  logic [4:0] A3_M,
  input  logic [4:0] A3_W,
  input  logic [2:0] res_E,
  input  logic [2:0] res_M,
  input  logic [2:0] res_W,
  input  logic       md_start_E,
  input  logic       md_is_div,
  input  logic       md_use_D,
  output logic       stall,
  output logic       stall_md,
  output logic       clrE,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic [1:0] fwd_rt_M,
  output logic [31:0] stall_cnt
);

  localparam logic [2:0] RES_NW  = 3'd0;
  localparam logic [2:0] RES_ALU = 3'd1;
  localparam logic [2:0] RES_DM  = 3'd2;
  localparam logic [2:0] RES_PC  = 3'd3;
  localparam logic [2:0] RES_MD  = 3'd4;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  // A producer matches only when it writes a real (non-$0) register with a defined result code.
  function automatic logic tag_hit(input logic [4:0] a, input logic [4:0] a3, input logic [2:0] res);
    tag_hit = (a != 5'd0) && (a == a3) && (res != RES_NW) && (res <= RES_MD);
  endfunction

  function automatic logic [1:0] tnew_e(input logic [2:0] res);
    case (res)
      RES_ALU, RES_MD: tnew_e = 2'd1;
      RES_DM:          tnew_e = 2'd2;
      default:         tnew_e = 2'd0;
    endcase
  endfunction

  function automatic logic ready_m(input logic [2:0] res);
    ready_m = (res == RES_ALU) || (res == RES_MD) || (res == RES_PC);
  endfunction

  function automatic logic [1:0] fwd_pick(input logic e_hit, input logic m_hit, input logic w_hit);
    fwd_pick = e_hit ? 2'd1 : m_hit ? 2'd2 : w_hit ? 2'd3 : 2'd0;
  endfunction

  logic [4:0] a_d [2];
  logic [1:0] tuse_min [2];
  logic [1:0] src_used;
  logic [1:0] src_hazard;
  logic [1:0] tnew_m;

  assign a_d[0]      = A1_D;
  assign a_d[1]      = A2_D;
  assign src_used[0] = Tuse_rs0 | Tuse_rs1;
  assign src_used[1] = Tuse_rt0 | Tuse_rt1 | Tuse_rt2;
  assign tuse_min[0] = Tuse_rs0 ? 2'd0 : 2'd1;
  assign tuse_min[1] = Tuse_rt0 ? 2'd0 : Tuse_rt1 ? 2'd1 : 2'd2;
  assign tnew_m      = (res_M == RES_DM) ? 2'd1 : 2'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hazard[gi] = src_used[gi] &&
        ((tag_hit(a_d[gi], A3_E, res_E) && (tnew_e(res_E) > tuse_min[gi])) ||
         (tag_hit(a_d[gi], A3_M, res_M) && (tnew_m > tuse_min[gi])));
    end
  endgenerate

  assign stall = |src_hazard;

  // Forwarding only from stages whose value is already final at the consumer.
  assign fwd_rs_D = fwd_pick(tag_hit(A1_D, A3_E, res_E) && (res_E == RES_PC),
                             tag_hit(A1_D, A3_M, res_M) && ready_m(res_M),
                             tag_hit(A1_D, A3_W, res_W));
  assign fwd_rt_D = fwd_pick(tag_hit(A2_D, A3_E, res_E) && (res_E == RES_PC),
                             tag_hit(A2_D, A3_M, res_M) && ready_m(res_M),
                             tag_hit(A2_D, A3_W, res_W));
  assign fwd_rs_E = fwd_pick(1'b0, tag_hit(A1_E, A3_M, res_M) && ready_m(res_M),
                             tag_hit(A1_E, A3_W, res_W));
  assign fwd_rt_E = fwd_pick(1'b0, tag_hit(A2_E, A3_M, res_M) && ready_m(res_M),
                             tag_hit(A2_E, A3_W, res_W));
  assign fwd_rt_M = fwd_pick(1'b0, 1'b0, tag_hit(A2_M, A3_W, res_W));

  logic [3:0] md_cnt_reg;
  logic       md_busy;

  // A new start always reloads, even if the unit is still busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_reg <= 4'd0;
    end else if (md_start_E) begin
      md_cnt_reg <= md_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt_reg != 4'd0) begin
      md_cnt_reg <= md_cnt_reg - 4'd1;
    end
  end

  assign md_busy  = (md_cnt_reg != 4'd0) | md_start_E;
  assign stall_md = md_busy & md_use_D;
  assign clrE     = stall | stall_md;

`ifdef HAZ_STALL_STATS_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= 32'd0;
    end else if (clrE && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2;
  logic [4:0] A1_D, A2_D, A1_E, A2_E, A2_M, A3_E, A3_M, A3_W;
  logic [2:0] res_E, res_M, res_W;
  logic       md_start_E, md_is_div, md_use_D;
  logic       stall, stall_md, clrE;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;
  logic [31:0] stall_cnt;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .Tuse_rs0(Tuse_rs0), .Tuse_rs1(Tuse_rs1), .Tuse_rt0(Tuse_rt0), .Tuse_rt1(Tuse_rt1), .Tuse_rt2(Tuse_rt2),
    .A1_D(A1_D), .A2_D(A2_D), .A1_E(A1_E), .A2_E(A2_E), .A2_M(A2_M),
    .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
    .res_E(res_E), .res_M(res_M), .res_W(res_W),
    .md_start_E(md_start_E), .md_is_div(md_is_div), .md_use_D(md_use_D),
    .stall(stall), .stall_md(stall_md), .clrE(clrE),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  logic [44:0] v_q [$];
  string       nm_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned run_cnt = 0;

  always @(negedge clk) begin
    if (v_q.size() > 0) begin
      logic [44:0] e, a;
      string nm;
      e  = v_q.pop_front();
      nm = nm_q.pop_front();
      a  = {stall, stall_md, clrE, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, stall_cnt};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", nm, a, e);
      end else begin
        $display("txn %s: outputs %h ok", nm, a);
      end
    end
  end

  task automatic zero_inputs();
    {Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2} = '0;
    {A1_D, A2_D, A1_E, A2_E, A2_M, A3_E, A3_M, A3_W} = '0;
    {res_E, res_M, res_W} = '0;
    {md_start_E, md_is_div, md_use_D} = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    zero_inputs();
  endtask

  // Expected stall_cnt counts prior edges (out of reset) where a stall was expected.
  task automatic expect_v(input string nm, input logic s, input logic m,
                          input logic [1:0] rsd, input logic [1:0] rtd,
                          input logic [1:0] rse, input logic [1:0] rte, input logic [1:0] rtm);
    logic [31:0] c_exp;
    if (!reset) run_cnt = 0;
`ifdef HAZ_STALL_STATS_EN
    c_exp = run_cnt;
`else
    c_exp = 32'd0;
`endif
    v_q.push_back({s, m, s | m, rsd, rtd, rse, rte, rtm, c_exp});
    nm_q.push_back(nm);
    if ((s | m) && reset) run_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    zero_inputs();
    next_cycle(); expect_v("reset_idle", 0, 0, 0, 0, 0, 0, 0);

    next_cycle(); reset = 1'b1;
    res_E = 3'd2; A3_E = 5'd1; A1_D = 5'd1; Tuse_rs0 = 1;
    expect_v("lw_E_beq", 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); res_M = 3'd2; A3_M = 5'd1; A1_D = 5'd1; Tuse_rs0 = 1;
    expect_v("lw_M_beq", 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); res_W = 3'd2; A3_W = 5'd1; A1_D = 5'd1; Tuse_rs0 = 1;
    expect_v("lw_W_beq", 0, 0, 3, 0, 0, 0, 0);
    next_cycle(); res_M = 3'd1; A3_M = 5'd2; A1_D = 5'd2; Tuse_rs1 = 1;
    expect_v("alu_M_D", 0, 0, 2, 0, 0, 0, 0);
    next_cycle(); res_W = 3'd1; A3_W = 5'd2; A1_E = 5'd2;
    expect_v("alu_W_E", 0, 0, 0, 0, 3, 0, 0);
    next_cycle(); res_M = 3'd1; A3_M = 5'd2; A1_E = 5'd2;
    expect_v("alu_M_E", 0, 0, 0, 0, 2, 0, 0);
    next_cycle(); res_E = 3'd3; A3_E = 5'd31; A1_D = 5'd31; Tuse_rs0 = 1;
    expect_v("jal_jr", 0, 0, 1, 0, 0, 0, 0);
    next_cycle(); res_E = 3'd1; res_M = 3'd1; res_W = 3'd1; Tuse_rs0 = 1; Tuse_rt0 = 1;
    expect_v("dest_zero", 0, 0, 0, 0, 0, 0, 0);
    next_cycle(); res_E = 3'd2; A3_E = 5'd6; A2_D = 5'd6; Tuse_rt2 = 1;
    expect_v("lw_rt2", 0, 0, 0, 0, 0, 0, 0);
    next_cycle(); res_E = 3'd2; A3_E = 5'd6; A2_D = 5'd6; Tuse_rt1 = 1; Tuse_rt2 = 1;
    expect_v("lw_rt1", 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); res_E = 3'd1; A3_E = 5'd6; A2_D = 5'd6; Tuse_rt1 = 1;
    expect_v("alu_rt1", 0, 0, 0, 0, 0, 0, 0);
    next_cycle(); res_E = 3'd4; A3_E = 5'd6; A2_D = 5'd6; Tuse_rt0 = 1;
    expect_v("mfhi_rt0", 1, 0, 0, 0, 0, 0, 0);
    next_cycle(); A1_D = 5'd5; res_E = 3'd3; A3_E = 5'd5; res_M = 3'd1; A3_M = 5'd5;
    res_W = 3'd2; A3_W = 5'd5; Tuse_rs0 = 1;
    expect_v("prio_E", 0, 0, 1, 0, 0, 0, 0);
    next_cycle(); A1_D = 5'd5; A1_E = 5'd5; A3_E = 5'd5; res_M = 3'd1; A3_M = 5'd5;
    res_W = 3'd2; A3_W = 5'd5; Tuse_rs0 = 1;
    expect_v("prio_M", 0, 0, 2, 0, 2, 0, 0);
    next_cycle(); A2_M = 5'd7; A2_E = 5'd7; A2_D = 5'd7; A3_W = 5'd7; res_W = 3'd2;
    expect_v("wb_rt", 0, 0, 0, 3, 0, 3, 3);
    next_cycle(); A3_E = 5'd4; A3_W = 5'd4; A1_D = 5'd4; A1_E = 5'd4; Tuse_rs0 = 1;
    expect_v("nw_dest", 0, 0, 0, 0, 0, 0, 0);
    next_cycle(); res_E = 3'd2; A3_E = 5'd1; A1_D = 5'd1;
    expect_v("no_tuse", 0, 0, 0, 0, 0, 0, 0);

    next_cycle(); md_start_E = 1; md_is_div = 1;
    expect_v("div_start", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      next_cycle(); md_use_D = 1;
      expect_v("div_busy", 0, 1, 0, 0, 0, 0, 0);
    end
    next_cycle(); md_use_D = 1;
    expect_v("div_done", 0, 0, 0, 0, 0, 0, 0);

    next_cycle(); md_start_E = 1; md_use_D = 1;
    expect_v("mult_start", 0, 1, 0, 0, 0, 0, 0);
    next_cycle(); md_use_D = 1;
    expect_v("mult_busy", 0, 1, 0, 0, 0, 0, 0);
    next_cycle(); md_use_D = 1; res_E = 3'd2; A3_E = 5'd1; A1_D = 5'd1; Tuse_rs0 = 1;
    expect_v("both_stalls", 1, 1, 0, 0, 0, 0, 0);
    next_cycle(); md_start_E = 1; md_is_div = 1; md_use_D = 1;
    expect_v("md_restart", 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      next_cycle(); md_use_D = (i != 4);
      expect_v("restart_busy", 0, (i != 4), 0, 0, 0, 0, 0);
    end
    next_cycle(); md_use_D = 1;
    expect_v("restart_done", 0, 0, 0, 0, 0, 0, 0);

    next_cycle(); md_start_E = 1; md_is_div = 1;
    expect_v("div2_start", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); md_use_D = 1;
      expect_v("div2_busy", 0, 1, 0, 0, 0, 0, 0);
    end
    next_cycle(); reset = 1'b0; md_use_D = 1;
    expect_v("reset_mid_div", 0, 0, 0, 0, 0, 0, 0);
    next_cycle(); reset = 1'b1; md_use_D = 1;
    expect_v("after_reset", 0, 0, 0, 0, 0, 0, 0);
    next_cycle(); md_start_E = 1; md_use_D = 1;
    expect_v("mult_after_reset", 0, 1, 0, 0, 0, 0, 0);

    next_cycle();
    for (int i = 0; i < 5; i++) begin
      if (v_q.size() == 0) break;
      @(posedge clk);
    end
    if (v_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d pending, required 0", v_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
